// File: rtl/shift_sequencer.sv
// Shift-sequence unit: one operand, a queue of shift commands applied one per cycle,
// result presented on a handshake once the command flagged last retires.
//
// state | meaning
// IDLE  | waiting for an operand; commands may already be queued
// RUN   | popping one command per cycle into the accumulator
// DONE  | result held on res_data until the consumer takes it
module shift_sequencer #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         load_ready,
    input  logic         cmd_valid,
    input  logic [1:0]   cmd_ctrl,
    input  logic [4:0]   cmd_shamt,
    input  logic         cmd_last,
    output logic         cmd_ready,
    output logic         res_valid,
    output logic [W-1:0] res_data,
    input  logic         res_ready,
    output logic         busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [7:0]     fifo_mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [AW:0]    count;
    logic           push, pop, full, empty;
    logic [7:0]     head;

    function automatic logic [W-1:0] shift_fn(input logic [W-1:0] a,
                                              input logic [1:0]   ctrl,
                                              input logic [4:0]   shamt);
        logic [2*W-1:0] dbl;
        int             amt;
        int             rot;
        amt = int'(shamt);
        rot = amt % W;
        dbl = {a, a} >> rot;
        case (ctrl)
            2'b00:   shift_fn = (amt >= W) ? '0 : a << amt;
            2'b01:   shift_fn = (amt >= W) ? '0 : a >> amt;
            2'b10:   shift_fn = (amt >= W) ? {W{a[W-1]}} : W'($signed(a) >>> amt);
            default: shift_fn = dbl[W-1:0];
        endcase
    endfunction

    // Push is refused whenever full, even if a pop frees a slot this cycle.
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign push      = cmd_valid && !full;
    assign cmd_ready = !full;
    assign head      = fifo_mem[rd_ptr];
    assign res_data  = acc_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_ctrl, cmd_shamt, cmd_last};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        pop        = 1'b0;
        load_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    acc_d   = load_data;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (!empty) begin
                    pop   = 1'b1;
                    acc_d = shift_fn(acc_q, head[7:6], head[5:1]);
                    if (head[0]) state_d = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: directed cases plus random sequences checked by a
// queue-based scoreboard against an arithmetic shift model.
module tb_shift_sequencer;

    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         load_valid, load_ready;
    logic [W-1:0] load_data;
    logic         cmd_valid, cmd_ready, cmd_last;
    logic [1:0]   cmd_ctrl;
    logic [4:0]   cmd_shamt;
    logic         res_valid, res_ready, busy;
    logic [W-1:0] res_data;

    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_q[$];
    bit           rr_rand  = 1'b0;

    always #5 clk = ~clk;

    shift_sequencer #(.W(W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_valid(load_valid),
        .load_data (load_data),
        .load_ready(load_ready),
        .cmd_valid (cmd_valid),
        .cmd_ctrl  (cmd_ctrl),
        .cmd_shamt (cmd_shamt),
        .cmd_last  (cmd_last),
        .cmd_ready (cmd_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy)
    );

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint pow2(input int s);
        return longint'(1) << s;
    endfunction

    // Shift semantics written as integer arithmetic on the operand value.
    function automatic logic [W-1:0] model_shift(input logic [W-1:0] a, input int ctrl, input int s);
        longint m;
        longint av;
        longint v;
        longint d;
        longint q;
        int     r;
        m  = pow2(W);
        av = longint'(a);
        case (ctrl)
            0: return (s >= W) ? '0 : W'((av * pow2(s)) % m);
            1: return W'(av / pow2(s));
            2: begin
                v = a[W-1] ? av - m : av;
                d = pow2(s);
                q = (v >= 0) ? v / d : -((-v + d - 1) / d);
                return W'(q & (m - 1));
            end
            default: begin
                r = s % W;
                return W'(av / pow2(r) + (av % pow2(r)) * pow2(W - r));
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input int ctrl, input int s, input bit last);
        int b;
        bit ok;
        b = 0;
        cmd_valid = 1'b1;
        cmd_ctrl  = 2'(ctrl);
        cmd_shamt = 5'(s);
        cmd_last  = last;
        do begin
            ok = cmd_ready;
            tick();
            b++;
        end while (!ok && b < 1000);
        cmd_valid = 1'b0;
        if (!ok) check("push_timeout", 0, 1);
    endtask

    task automatic load_op(input logic [W-1:0] a);
        int b;
        bit ok;
        b = 0;
        load_valid = 1'b1;
        load_data  = a;
        do begin
            ok = load_ready;
            tick();
            b++;
        end while (!ok && b < 1000);
        load_valid = 1'b0;
        if (!ok) check("load_timeout", 0, 1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (!(exp_q.size() == 0 && load_ready) && b < 3000) begin
            tick();
            b++;
        end
        if (b >= 3000) check("drain_timeout", 0, 1);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_res_data"}, res_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_load_ready"}, load_ready, 1);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
    endtask

    // Asserts reset mid-cycle from the current posedge+1 position.
    task automatic apply_reset(input string tag);
        #3;
        reset      = 1'b1;
        load_valid = 1'b0;
        cmd_valid  = 1'b0;
        exp_q.delete();
        #1;
        reset_checks(tag);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick();
        reset_checks({tag, "_rel"});
    endtask

    task automatic directed1(input logic [W-1:0] a, input int c, input int s,
                             input logic [W-1:0] expv);
        exp_q.push_back(expv);
        push_cmd(c, s, 1'b1);
        load_op(a);
        drain();
    endtask

    task automatic run_random_seq();
        logic [W-1:0] a;
        logic [W-1:0] e;
        int           n;
        bit           pre;
        int           ctl[6];
        int           sh[6];
        a   = W'($urandom);
        n   = $urandom_range(1, 6);
        pre = (n <= DEPTH) && ($urandom_range(0, 1) == 1);
        e   = a;
        for (int i = 0; i < n; i++) begin
            ctl[i] = $urandom_range(0, 3);
            sh[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, W);
            e      = model_shift(e, ctl[i], sh[i]);
        end
        exp_q.push_back(e);
        if (!pre) load_op(a);
        for (int i = 0; i < n; i++) push_cmd(ctl[i], sh[i], i == n - 1);
        if (pre) load_op(a);
    endtask

    // Scoreboard monitor: the handshake happens at the posedge following this negedge.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", res_data, 0);
                if (res_data == 0) check("unexpected_result", 1, 0);
            end else begin
                check("result", res_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_rand) res_ready = ($urandom_range(0, 1) == 1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        int b;
        reset      = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        cmd_valid  = 1'b0;
        cmd_ctrl   = '0;
        cmd_shamt  = '0;
        cmd_last   = 1'b0;
        res_ready  = 1'b1;
        #12;
        reset_checks("por");
        @(negedge clk);
        reset = 1'b0;
        tick();
        reset_checks("por_rel");

        // Two-step sequence, pre-queued: result two edges after the load.
        res_ready = 1'b0;
        push_cmd(0, 1, 1'b0);
        push_cmd(2, 2, 1'b1);
        exp_q.push_back(8'h0B);
        load_op(8'h96);
        check("lat_t0_valid", res_valid, 0);
        tick();
        check("lat_t1_valid", res_valid, 0);
        check("lat_t1_acc", res_data, 8'h2C);
        tick();
        check("lat_t2_valid", res_valid, 1);
        check("lat_t2_data", res_data, 8'h0B);
        res_ready = 1'b1;
        drain();

        directed1(8'h80, 2, 3, 8'hF0);
        directed1(8'h80, 2, 12, 8'hFF);
        directed1(8'hFF, 0, 8, 8'h00);
        directed1(8'hFF, 1, 31, 8'h00);

        exp_q.push_back(8'h60);
        push_cmd(3, 1, 1'b0);
        push_cmd(3, 0, 1'b0);
        push_cmd(3, 9, 1'b1);
        load_op(8'h81);
        drain();

        // Fill, refuse a fifth push, then drain; repeated to wrap the pointers.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 4; i++) push_cmd(0, 1, i == 3);
            check("full_ready", cmd_ready, 0);
            cmd_valid = 1'b1;
            cmd_ctrl  = 2'd1;
            cmd_shamt = 5'd1;
            cmd_last  = 1'b1;
            tick();
            cmd_valid = 1'b0;
            check("full_refused", cmd_ready, 0);
            exp_q.push_back(8'h10);
            load_op(8'h01);
            tick();
            check("ready_after_pop", cmd_ready, 1);
            drain();
        end
        directed1(8'h01, 0, 2, 8'h04);

        // Back-pressure with a full queue of next-sequence commands.
        res_ready = 1'b0;
        exp_q.push_back(8'h0C);
        push_cmd(0, 2, 1'b1);
        load_op(8'h03);
        b = 0;
        while (!res_valid && b < 50) begin
            tick();
            b++;
        end
        check("bp_reached_done", res_valid, 1);
        for (int i = 0; i < 4; i++) push_cmd(0, 1, i == 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", res_valid, 1);
            check("bp_data", res_data, 8'h0C);
            check("bp_no_pop", cmd_ready, 0);
        end
        exp_q.push_back(8'h10);
        res_ready = 1'b1;
        load_op(8'h01);
        drain();

        // Starvation: RUN with nothing queued holds the accumulator.
        load_op(8'h5A);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("starve_busy", busy, 1);
            check("starve_acc", res_data, 8'h5A);
            check("starve_valid", res_valid, 0);
        end
        exp_q.push_back(8'h05);
        push_cmd(1, 4, 1'b1);
        drain();

        // Reset during RUN with two commands still queued.
        for (int i = 0; i < 3; i++) push_cmd(0, 1, 1'b0);
        load_op(8'h33);
        tick();
        check("mid_run_busy", busy, 1);
        apply_reset("mid_run");
        exp_q.push_back(8'h02);
        load_op(8'h01);
        push_cmd(0, 1, 1'b1);
        drain();

        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) run_random_seq();
        drain();
        rr_rand   = 1'b0;
        res_ready = 1'b1;
        tick();
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
